rom_loader: RTL

Boot-time program loader that fills the instruction ROM over a byte stream. It accepts a framed image (length, payload, checksum) on a valid/ready byte interface and assembles little-endian 32-bit instruction words. Each word is written into the instruction memory through its write port (address, data, one-cycle write enable). The core stays in hold until a frame has loaded and its checksum has passed.

---
 rtl/rom_loader_pkg.sv | 29 ++
 rtl/rom_loader_asm.sv | 54 +++++
 rtl/rom_loader.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/rom_loader_pkg.sv
// Shared definitions for the boot ROM loader: widths, FSM encoding,
// frame constants and the default load address.
package rom_loader_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned LEN_W   = 16;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned LANES_W = WORD_W - BYTE_W;

    localparam logic [WORD_W-1:0] DEFAULT_BASE_ADDR = 32'h0000_0000;
    localparam int unsigned       DEFAULT_MAX_WORDS = 1024;

    // XOR of a whole valid frame, checksum byte included
    localparam logic [BYTE_W-1:0] CHK_RESIDUE = 8'h00;
    localparam logic [WORD_W-1:0] WORD_STRIDE = 32'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_CHK   = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } state_t;

endpackage

// File: rtl/rom_loader_asm.sv
// Byte-lane assembler and running XOR for the ROM loader.
// Ports: clr resets index and XOR; accept folds data into the XOR;
// lane_en stores data into the current lane and advances the index.
// word is the completed word assuming data is lane 3; word_full flags
// that the next lane byte completes the word; xor_zero flags that
// folding data now leaves a zero checksum.
module rom_loader_asm
    import rom_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              accept,
    input  logic              lane_en,
    input  logic [BYTE_W-1:0] data,
    output logic [WORD_W-1:0] word,
    output logic              word_full,
    output logic              xor_zero
);

    logic [IDX_W-1:0]   idx_q;
    logic [LANES_W-1:0] lanes_q;
    logic [BYTE_W-1:0]  xor_q;

    // Only lanes 0..2 are stored; lane 3 comes straight from data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            lanes_q <= '0;
            xor_q   <= '0;
        end else if (clr) begin
            idx_q <= '0;
            xor_q <= '0;
        end else begin
            if (accept) begin
                xor_q <= xor_q ^ data;
            end
            if (lane_en) begin
                idx_q <= idx_q + IDX_W'(1);
                case (idx_q)
                    2'd0:    lanes_q[7:0]   <= data;
                    2'd1:    lanes_q[15:8]  <= data;
                    2'd2:    lanes_q[23:16] <= data;
                    default: ;
                endcase
            end
        end
    end

    assign word      = {data, lanes_q};
    assign word_full = (idx_q == IDX_W'(3));
    assign xor_zero  = ((xor_q ^ data) == CHK_RESIDUE);

endmodule

// File: rtl/rom_loader.sv
// Boot-time loader: receives a framed image (length, payload, checksum)
// over a valid/ready byte stream and writes little-endian 32-bit words
// into the instruction memory; releases the core hold once the frame's
// checksum is good.
// Ports: start_i arms a new frame; rx_* byte stream; inst_addr_o/inst_o/
// winst_en_o memory write port; busy_o/done_o/err_o status; hold_o core hold.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter logic [WORD_W-1:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int unsigned       MAX_WORDS = DEFAULT_MAX_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [BYTE_W-1:0] rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic [WORD_W-1:0] inst_addr_o,
    output logic [WORD_W-1:0] inst_o,
    output logic              winst_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              hold_o
);

    state_t             state_q, state_d;
    logic               xfer;
    logic               asm_clr, asm_accept, asm_lane_en;
    logic [WORD_W-1:0]  asm_word;
    logic               asm_word_full, asm_xor_zero;
    logic [BYTE_W-1:0]  len_lo_q;
    logic [LEN_W-1:0]   len_q, cnt_q;
    logic [LEN_W-1:0]   len_c;

    assign rx_ready_o = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                        (state_q == ST_DATA) || (state_q == ST_CHK);
    assign xfer  = rx_valid_i && rx_ready_o;
    assign len_c = {rx_data_i, len_lo_q};

    rom_loader_asm u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (asm_clr),
        .accept    (asm_accept),
        .lane_en   (asm_lane_en),
        .data      (rx_data_i),
        .word      (asm_word),
        .word_full (asm_word_full),
        .xor_zero  (asm_xor_zero)
    );

    // Next-state and assembler control
    always_comb begin
        state_d     = state_q;
        asm_clr     = 1'b0;
        asm_accept  = 1'b0;
        asm_lane_en = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_i) begin
                    state_d = ST_LEN0;
                    asm_clr = 1'b1;
                end
            end
            ST_LEN0: begin
                if (xfer) begin
                    asm_accept = 1'b1;
                    state_d    = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (xfer) begin
                    asm_accept = 1'b1;
                    if (32'(len_c) > MAX_WORDS) begin
                        state_d = ST_ERR;
                    end else if (len_c == '0) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    asm_accept  = 1'b1;
                    asm_lane_en = 1'b1;
                    if (asm_word_full) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                state_d = (LEN_W'(cnt_q + LEN_W'(1)) == len_q) ? ST_CHK : ST_DATA;
            end
            ST_CHK: begin
                if (xfer) begin
                    asm_accept = 1'b1;
                    state_d    = asm_xor_zero ? ST_DONE : ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counters, address and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_lo_q    <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            inst_addr_o <= BASE_ADDR;
            inst_o      <= '0;
            winst_en_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            hold_o      <= 1'b1;
        end else begin
            state_q    <= state_d;
            winst_en_o <= (state_d == ST_WRITE);
            busy_o     <= (state_d == ST_LEN0) || (state_d == ST_LEN1) ||
                          (state_d == ST_DATA) || (state_d == ST_WRITE) ||
                          (state_d == ST_CHK);
            done_o     <= (state_d == ST_DONE);
            err_o      <= (state_d == ST_ERR);
            hold_o     <= (state_d != ST_DONE);
            if (asm_clr) begin
                cnt_q       <= '0;
                inst_addr_o <= BASE_ADDR;
            end
            if ((state_q == ST_LEN0) && xfer) begin
                len_lo_q <= rx_data_i;
            end
            if ((state_q == ST_LEN1) && xfer) begin
                len_q <= len_c;
            end
            // Capture the word as its last byte arrives so it is stable during WRITE
            if (asm_lane_en && asm_word_full) begin
                inst_o <= asm_word;
            end
            if (state_q == ST_WRITE) begin
                inst_addr_o <= inst_addr_o + WORD_STRIDE;
                cnt_q       <= cnt_q + LEN_W'(1);
            end
        end
    end

endmodule
